// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution stream engine.
// Coefficient signedness is chosen in the top via CONV_SIGNED_COEF_EN.
package conv_pkg;

   typedef enum logic [1:0] {
      FILL0,
      FILL1,
      RUN
   } win_state_e;

   localparam int KERNEL_TAPS = 9;

   // One bit per tap, row-major; only the centre tap is set.
   localparam logic [KERNEL_TAPS-1:0] IDENTITY_KERNEL = 9'b0_0001_0000;

   function automatic bit accWidthOk(input int pixW, input int accW);
      return accW >= 2 * pixW + 5;
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with a registered occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo_fwft #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       wrEn_i,
   input  logic [WIDTH-1:0]           wrData_i,
   input  logic                       rdEn_i,
   output logic [WIDTH-1:0]           rdData_o,
   output logic                       empty_o,
   output logic                       full_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wrPtr_q;
   logic [AW-1:0]    rdPtr_q;
   logic [AW:0]      count_q;
   logic             wrFire;
   logic             rdFire;

   assign empty_o  = (count_q == '0);
   assign full_o   = (count_q == FullCount);
   assign rdFire   = rdEn_i && !empty_o;
   // A read in the same cycle frees a slot, so a full FIFO still takes the write.
   assign wrFire   = wrEn_i && (!full_o || rdFire);
   assign rdData_o = mem_q[rdPtr_q];
   assign count_o  = count_q;

   always_ff @(posedge clk_i) begin
      if (wrFire) begin
         mem_q[wrPtr_q] <= wrData_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (wrFire) begin
            wrPtr_q <= wrPtr_q + AW'(1);
         end
         if (rdFire) begin
            rdPtr_q <= rdPtr_q + AW'(1);
         end
         case ({wrFire, rdFire})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/conv3x3_stream_engine.sv
// Streaming 3x3 convolution: column window, loadable kernel, 2-stage MAC, FWFT output FIFO.
// Define CONV_SIGNED_COEF_EN for two's-complement coefficients and a signed result.
module conv3x3_stream_engine
   import conv_pkg::*;
#(
   parameter int PIX_W      = 8,
   parameter int ACC_W      = 22,
   parameter int IMG_W      = 512,
   parameter int FIFO_DEPTH = 16,
   parameter int PROG_FULL  = 12
) (
   input  logic             axi_clk,
   input  logic             axi_reset_n,
   input  logic             i_data_valid,
   input  logic [PIX_W-1:0] i_data1,
   input  logic [PIX_W-1:0] i_data2,
   input  logic [PIX_W-1:0] i_data3,
   output logic             o_data_ready,
   output logic             o_data_valid,
   output logic [ACC_W-1:0] o_data,
   input  logic             i_data_ready,
   input  logic             i_coef_wr,
   input  logic [3:0]       i_coef_addr,
   input  logic [PIX_W-1:0] i_coef_data,
   output logic             o_intr
);

   localparam int CW = $clog2(IMG_W);
   localparam int FCW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] LastCol = CW'(IMG_W - 1);

   if (!accWidthOk(PIX_W, ACC_W)) begin : gAccWidthCheck
      $error("conv3x3_stream_engine: ACC_W too narrow for PIX_W");
   end
   if (PROG_FULL > FIFO_DEPTH - 3) begin : gProgFullCheck
      $error("conv3x3_stream_engine: PROG_FULL leaves no room for in-flight results");
   end

   win_state_e        state_q;
   logic [CW-1:0]     colCnt_q;
   logic              intr_q;
   logic              ready_q;
   logic              prodValid_q;
   logic              sumValid_q;
   logic [PIX_W-1:0]  coef_q [KERNEL_TAPS];
   logic [PIX_W-1:0]  colA_q [3];
   logic [PIX_W-1:0]  colB_q [3];
   logic [PIX_W-1:0]  newCol [3];
   logic [PIX_W-1:0]  winPix [KERNEL_TAPS];
   logic [ACC_W-1:0]  prod_q [KERNEL_TAPS];
   logic [ACC_W-1:0]  sum_d;
   logic [ACC_W-1:0]  sum_q;
   logic              accept;
   logic              fifoEmpty;
   logic              fifoFull;
   logic              fifoRd;
   logic [ACC_W-1:0]  fifoData;
   logic [FCW-1:0]    fifoCount;

`ifdef CONV_SIGNED_COEF_EN
   function automatic logic [ACC_W-1:0] tapProduct(input logic [PIX_W-1:0] c,
                                                   input logic [PIX_W-1:0] p);
      logic signed [2*PIX_W:0] cs;
      logic signed [2*PIX_W:0] ps;
      logic signed [2*PIX_W:0] prod;
      cs   = $signed({{(PIX_W+1){c[PIX_W-1]}}, c});
      ps   = $signed({{(PIX_W+1){1'b0}}, p});
      prod = cs * ps;
      return {{(ACC_W-2*PIX_W-1){prod[2*PIX_W]}}, prod};
   endfunction
`else
   function automatic logic [ACC_W-1:0] tapProduct(input logic [PIX_W-1:0] c,
                                                   input logic [PIX_W-1:0] p);
      logic [2*PIX_W-1:0] prod;
      prod = {{PIX_W{1'b0}}, c} * {{PIX_W{1'b0}}, p};
      return {{(ACC_W-2*PIX_W){1'b0}}, prod};
   endfunction
`endif

   assign accept    = i_data_valid && ready_q;
   assign newCol[0] = i_data1;
   assign newCol[1] = i_data2;
   assign newCol[2] = i_data3;

   // Kernel RAM; columns accepted on a write cycle still see the old coefficients.
   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         for (int k = 0; k < KERNEL_TAPS; k++) begin
            coef_q[k] <= {{(PIX_W-1){1'b0}}, IDENTITY_KERNEL[k]};
         end
      end else if (i_coef_wr && (i_coef_addr < 4'(KERNEL_TAPS))) begin
         coef_q[i_coef_addr] <= i_coef_data;
      end
   end

   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         state_q     <= FILL0;
         colCnt_q    <= '0;
         intr_q      <= 1'b0;
         prodValid_q <= 1'b0;
      end else begin
         intr_q      <= 1'b0;
         prodValid_q <= 1'b0;
         if (accept) begin
            prodValid_q <= (state_q == RUN);
            if (colCnt_q == LastCol) begin
               colCnt_q <= '0;
               state_q  <= FILL0;
               intr_q   <= 1'b1;
            end else begin
               colCnt_q <= colCnt_q + CW'(1);
               case (state_q)
                  FILL0:   state_q <= FILL1;
                  default: state_q <= RUN;
               endcase
            end
         end
      end
   end

   // Tap k sits at row k/3, column k%3; column 2 is the incoming column.
   always_comb begin
      for (int k = 0; k < KERNEL_TAPS; k++) begin
         winPix[k] = newCol[k / 3];
         if ((k % 3) == 0) begin
            winPix[k] = colA_q[k / 3];
         end else if ((k % 3) == 1) begin
            winPix[k] = colB_q[k / 3];
         end
      end
   end

   always_comb begin
      sum_d = '0;
      for (int k = 0; k < KERNEL_TAPS; k++) begin
         sum_d = sum_d + prod_q[k];
      end
   end

   always_ff @(posedge axi_clk) begin
      if (accept) begin
         for (int r = 0; r < 3; r++) begin
            colA_q[r] <= colB_q[r];
            colB_q[r] <= newCol[r];
         end
      end
      for (int k = 0; k < KERNEL_TAPS; k++) begin
         prod_q[k] <= tapProduct(coef_q[k], winPix[k]);
      end
      sum_q <= sum_d;
   end

   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         sumValid_q <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         sumValid_q <= prodValid_q;
         ready_q    <= (fifoCount < FCW'(PROG_FULL)) && !fifoFull;
      end
   end

   sync_fifo_fwft #(
      .WIDTH (ACC_W),
      .DEPTH (FIFO_DEPTH)
   ) uOutFifo (
      .clk_i    (axi_clk),
      .rst_n_i  (axi_reset_n),
      .wrEn_i   (sumValid_q),
      .wrData_i (sum_q),
      .rdEn_i   (fifoRd),
      .rdData_o (fifoData),
      .empty_o  (fifoEmpty),
      .full_o   (fifoFull),
      .count_o  (fifoCount)
   );

   assign o_data_valid = !fifoEmpty;
   assign fifoRd       = o_data_valid && i_data_ready;
   assign o_data       = o_data_valid ? fifoData : '0;
   assign o_data_ready = ready_q;
   assign o_intr       = intr_q;

endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// Scoreboard bench for conv3x3_stream_engine with IMG_W = 5 and directed pixel rows.
// Expected results are hand-computed per column and queued when the column is accepted.
module tb_conv3x3_stream_engine;

   localparam int PIX_W      = 8;
   localparam int ACC_W      = 22;
   localparam int IMG_W      = 5;
   localparam int FIFO_DEPTH = 16;
   localparam int PROG_FULL  = 12;
   localparam int TIMEOUT    = 300;

`ifdef CONV_SIGNED_COEF_EN
   localparam logic [ACC_W-1:0] SOBEL_EXP = 22'h3FFE70;
`else
   localparam logic [ACC_W-1:0] SOBEL_EXP = 22'd76400;
`endif

   typedef logic [PIX_W-1:0] kernel_t [9];
   localparam kernel_t IDENTITY_K = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
   localparam kernel_t ONES_K     = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
   localparam kernel_t SOBEL_K    = '{8'hFF, 8'd0, 8'd1, 8'hFE, 8'd0, 8'd2, 8'hFF, 8'd0, 8'd1};

   logic             axi_clk = 1'b0;
   logic             axi_reset_n;
   logic             i_data_valid;
   logic [PIX_W-1:0] i_data1;
   logic [PIX_W-1:0] i_data2;
   logic [PIX_W-1:0] i_data3;
   logic             o_data_ready;
   logic             o_data_valid;
   logic [ACC_W-1:0] o_data;
   logic             i_data_ready;
   logic             i_coef_wr;
   logic [3:0]       i_coef_addr;
   logic [PIX_W-1:0] i_coef_data;
   logic             o_intr;

   logic [ACC_W-1:0] expQ [$];
   int testCount       = 0;
   int failCount       = 0;
   int cycleCnt        = 0;
   int intrCount       = 0;
   int firstValidCycle = -1;
   int lastAcceptCycle = 0;
   int latStart        = 0;

   conv3x3_stream_engine #(
      .PIX_W      (PIX_W),
      .ACC_W      (ACC_W),
      .IMG_W      (IMG_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .PROG_FULL  (PROG_FULL)
   ) dut (
      .axi_clk      (axi_clk),
      .axi_reset_n  (axi_reset_n),
      .i_data_valid (i_data_valid),
      .i_data1      (i_data1),
      .i_data2      (i_data2),
      .i_data3      (i_data3),
      .o_data_ready (o_data_ready),
      .o_data_valid (o_data_valid),
      .o_data       (o_data),
      .i_data_ready (i_data_ready),
      .i_coef_wr    (i_coef_wr),
      .i_coef_addr  (i_coef_addr),
      .i_coef_data  (i_coef_data),
      .o_intr       (o_intr)
   );

   always #5 axi_clk = ~axi_clk;

   always @(posedge axi_clk) cycleCnt <= cycleCnt + 1;

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      testCount++;
      if (actual != expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Offers one column and waits (bounded) for it to be accepted.
   task automatic applyStimulus(input logic [PIX_W-1:0] p1, input logic [PIX_W-1:0] p2,
                                input logic [PIX_W-1:0] p3, input bit hasExp,
                                input logic [ACC_W-1:0] expVal);
      int  waited = 0;
      bit  taken  = 1'b0;
      @(negedge axi_clk);
      i_data_valid = 1'b1;
      i_data1 = p1;
      i_data2 = p2;
      i_data3 = p3;
      while (!taken) begin
         if (o_data_ready) begin
            taken = 1'b1;
            lastAcceptCycle = cycleCnt;
            if (hasExp) expQ.push_back(expVal);
         end
         @(posedge axi_clk);
         if (!taken) begin
            waited++;
            if (waited > TIMEOUT) begin
               checkOutput("accept_timeout", 0, 1);
               break;
            end
            @(negedge axi_clk);
         end
      end
   endtask

   task automatic idleInput();
      @(negedge axi_clk);
      i_data_valid = 1'b0;
   endtask

   task automatic sendRow(input logic [PIX_W-1:0] p1, input logic [PIX_W-1:0] p2,
                          input logic [PIX_W-1:0] p3, input logic [ACC_W-1:0] expVal);
      for (int j = 0; j < IMG_W; j++) applyStimulus(p1, p2, p3, j >= 2, expVal);
   endtask

   task automatic loadCoef(input logic [3:0] addr, input logic [PIX_W-1:0] data);
      @(negedge axi_clk);
      i_coef_wr   = 1'b1;
      i_coef_addr = addr;
      i_coef_data = data;
      @(negedge axi_clk);
      i_coef_wr   = 1'b0;
   endtask

   task automatic loadKernel(input kernel_t kern);
      for (int k = 0; k < 9; k++) loadCoef(4'(k), kern[k]);
   endtask

   task automatic waitDrain(input string name);
      for (int w = 0; w < TIMEOUT; w++) begin
         @(negedge axi_clk);
         #3;
         if (expQ.size() == 0 && !o_data_valid) break;
      end
      checkOutput({name, "_pending"}, expQ.size(), 0);
   endtask

   // Monitor: pops the scoreboard on every handshake; idle data must read as zero.
   always @(negedge axi_clk) begin
      #2;
      if (axi_reset_n) begin
         if (o_intr) intrCount++;
         if (o_data_valid) begin
            if (firstValidCycle < 0) firstValidCycle = cycleCnt;
            if (i_data_ready) begin
               if (expQ.size() == 0) begin
                  testCount++;
                  failCount++;
                  $display("[TB] FAIL unexpected_result: got %0d, expected no result", o_data);
               end else begin
                  checkOutput("result", longint'(o_data), longint'(expQ.pop_front()));
               end
            end
         end else begin
            checkOutput("idle_data_zero", longint'(o_data), 0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got no completion, expected finish within time limit");
      $fatal(1);
   end

   initial begin
      axi_reset_n  = 1'b0;
      i_data_valid = 1'b0;
      i_data1      = '0;
      i_data2      = '0;
      i_data3      = '0;
      i_data_ready = 1'b0;
      i_coef_wr    = 1'b0;
      i_coef_addr  = '0;
      i_coef_data  = '0;

      repeat (3) @(negedge axi_clk);
      #1;
      checkOutput("reset_valid", o_data_valid, 0);
      checkOutput("reset_data", longint'(o_data), 0);
      checkOutput("reset_intr", o_intr, 0);
      checkOutput("reset_ready", o_data_ready, 0);
      @(negedge axi_clk);
      axi_reset_n = 1'b1;
      @(negedge axi_clk);
      #1;
      checkOutput("ready_after_reset", o_data_ready, 1);

      // Identity kernel, two rows: centre pixel 20 per window.
      i_data_ready    = 1'b1;
      intrCount       = 0;
      firstValidCycle = -1;
      applyStimulus(8'd10, 8'd20, 8'd30, 1'b0, '0);
      applyStimulus(8'd10, 8'd20, 8'd30, 1'b0, '0);
      applyStimulus(8'd10, 8'd20, 8'd30, 1'b1, 22'd20);
      latStart = lastAcceptCycle;
      applyStimulus(8'd10, 8'd20, 8'd30, 1'b1, 22'd20);
      applyStimulus(8'd10, 8'd20, 8'd30, 1'b1, 22'd20);
      sendRow(8'd10, 8'd20, 8'd30, 22'd20);
      idleInput();
      waitDrain("identity");
      checkOutput("identity_latency", firstValidCycle - latStart, 3);
      checkOutput("identity_intr_count", intrCount, 2);

      // All-ones kernel over saturated pixels; out-of-range addresses must be ignored.
      loadKernel(ONES_K);
      loadCoef(4'd9, 8'd5);
      loadCoef(4'd15, 8'd5);
      sendRow(8'd255, 8'd255, 8'd255, 22'd2295);
      idleInput();
      waitDrain("ones");

      // Sobel-x over a left-bright edge.
      loadKernel(SOBEL_K);
      applyStimulus(8'd100, 8'd100, 8'd100, 1'b0, '0);
      applyStimulus(8'd100, 8'd100, 8'd100, 1'b0, '0);
      applyStimulus(8'd0, 8'd0, 8'd0, 1'b1, SOBEL_EXP);
      applyStimulus(8'd0, 8'd0, 8'd0, 1'b1, SOBEL_EXP);
      applyStimulus(8'd0, 8'd0, 8'd0, 1'b1, 22'd0);
      idleInput();
      waitDrain("sobel");

      // Backpressure: identity result at column i is the middle pixel of column i-1, i.e. i.
      loadKernel(IDENTITY_K);
      @(negedge axi_clk);
      i_data_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 25; i++) begin
               applyStimulus(8'd200, PIX_W'(i + 1), 8'd50, (i % IMG_W) >= 2, ACC_W'(i));
            end
            idleInput();
         end
         begin
            int  waited;
            int  run;
            bit  seenLow;
            waited  = 0;
            run     = 0;
            seenLow = 1'b0;
            @(negedge axi_clk);
            while (waited < TIMEOUT) begin
               #1;
               if (!o_data_ready) begin
                  seenLow = 1'b1;
                  checkOutput("bp_fill_level_12_to_15",
                              (expQ.size() >= PROG_FULL) && (expQ.size() <= PROG_FULL + 3), 1);
                  break;
               end
               @(negedge axi_clk);
               waited++;
            end
            checkOutput("bp_ready_fell", seenLow, 1);
            repeat (5) @(negedge axi_clk);
            i_data_ready = 1'b1;
            for (int k = 0; k < 20; k++) begin
               #1;
               if (!o_data_valid) break;
               run++;
               @(negedge axi_clk);
            end
            checkOutput("bp_drain_run_ge_12", run >= PROG_FULL, 1);
         end
      join
      waitDrain("backpressure");

      // Reset mid-row with results parked in the FIFO.
      loadKernel(ONES_K);
      @(negedge axi_clk);
      i_data_ready = 1'b0;
      sendRow(8'd1, 8'd2, 8'd3, 22'd18);
      sendRow(8'd1, 8'd2, 8'd3, 22'd18);
      for (int j = 0; j < 4; j++) applyStimulus(8'd1, 8'd2, 8'd3, j >= 2, 22'd18);
      idleInput();
      repeat (4) @(negedge axi_clk);
      checkOutput("prereset_valid", o_data_valid, 1);
      @(negedge axi_clk);
      axi_reset_n = 1'b0;
      expQ.delete();
      #1;
      checkOutput("midreset_valid", o_data_valid, 0);
      checkOutput("midreset_data", longint'(o_data), 0);
      checkOutput("midreset_intr", o_intr, 0);
      checkOutput("midreset_ready", o_data_ready, 0);
      repeat (2) @(negedge axi_clk);
      axi_reset_n     = 1'b1;
      i_data_ready    = 1'b1;
      firstValidCycle = -1;
      applyStimulus(8'd4, 8'd7, 8'd9, 1'b0, '0);
      applyStimulus(8'd4, 8'd7, 8'd9, 1'b0, '0);
      applyStimulus(8'd4, 8'd7, 8'd9, 1'b1, 22'd7);
      latStart = lastAcceptCycle;
      applyStimulus(8'd4, 8'd7, 8'd9, 1'b1, 22'd7);
      applyStimulus(8'd4, 8'd7, 8'd9, 1'b1, 22'd7);
      idleInput();
      waitDrain("post_reset");
      checkOutput("post_reset_latency", firstValidCycle - latStart, 3);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
